stream_demux: RTL and testbench
===============================

// Module: stream_demux
//
// PURPOSE
//   Parametrised, registered 1:N demultiplexer for a valid/ready data stream.
//   Routes each accepted input beat to one output channel (addressed or
//   round-robin) or to all channels (broadcast).
//   Each channel has a one-entry output register, so every output is
//   registered and can stall independently.
//   Sits between a single producer and N independent consumers.
//
// PARAMETERS
//   N      4   number of output channels, 2..16
//   WIDTH  8   data width in bits, >=1
//   SEL_W  2   select width; must equal $clog2(N)
//
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-high
//   mode       in   2        00 ADDR, 01 RR, 10 BCAST, 11 reserved
//   in_valid   in   1        input beat present
//   in_ready   out  1        input beat can be accepted (combinational)
//   in_data    in   WIDTH    input payload
//   in_sel     in   SEL_W    target channel in ADDR mode
//   out_valid  out  N        per-channel data valid (registered)
//   out_ready  in   N        per-channel consumer ready
//   out_data   out  N*WIDTH  channel k = out_data[k*WIDTH +: WIDTH] (registered)
//   err        out  1        one-cycle pulse: illegal in_sel beat was dropped
//
// BEHAVIOUR
//   Definitions
//   - free[k] = !out_valid[k] | out_ready[k]; slot k is empty or draining this cycle.
//   - accept = in_valid & in_ready.
//   - Channel k drains when out_valid[k] & out_ready[k].
//
//   Input ready and routing, per mode
//   - ADDR: if in_sel < N, in_ready = free[in_sel] and the beat loads channel in_sel.
//   - ADDR: if in_sel >= N, in_ready = 1; the beat is dropped and err = 1 on the next cycle.
//   - RR: in_ready = free[rr_ptr]; the beat loads channel rr_ptr.
//     On accept, rr_ptr advances by one and wraps from N-1 to 0.
//     rr_ptr holds its value when there is no accept.
//   - BCAST: in_ready = &free; the beat loads every channel in the same cycle.
//   - 11 (reserved): in_ready = 0; nothing is accepted; outputs keep draining.
//   - in_ready depends combinationally on mode, in_sel, rr_ptr, out_valid and
//     out_ready. It does not depend on in_valid.
//
//   Output channels
//   - Latency: a beat accepted at edge t appears on out_data/out_valid after edge t.
//   - Load and drain on the same channel in the same cycle: the new data is
//     registered and out_valid stays 1 (back-to-back throughput of 1 beat/cycle).
//   - Drain with no load: out_valid[k] goes to 0 at the next edge.
//   - Hold: while out_valid[k] & !out_ready[k], out_data for channel k is stable.
//   - out_data is not cleared on drain; it is don't-care while out_valid is 0.
//
//   Mode changes
//   - mode may change on any cycle. It affects only that cycle's routing.
//   - Data already held in the channel registers is not affected.
//   - rr_ptr is kept across mode changes; it is never reset by a mode change.
//
//   Reset (asynchronous, active-high)
//   - out_valid = 0, out_data = 0, rr_ptr = 0, err = 0.
//   - in_ready = 0 while rst is high.
//   - Asserting rst mid-transfer discards all held beats immediately.
//   - Operation resumes on the first clock edge after rst is released.
//
// TESTING  (default N=4, WIDTH=8 unless noted)
//   1. ADDR, out_ready=4'b1111; send 0x11..0x44 with in_sel 0..3 on consecutive cycles
//      -> each value appears one cycle later on its matching channel; in_ready stays 1.
//   2. ADDR, out_ready[2]=0; two beats with in_sel=2 (0xA5, then 0x5A)
//      -> 0xA5 held on ch2, in_ready=0 on the second beat.
//      -> raise out_ready[2]: 0xA5 drains and 0x5A loads in the same cycle; out_valid[2] stays 1.
//   3. RR, all ready; 6 beats 1..6
//      -> channels 0,1,2,3,0,1 in that order; rr_ptr=2 afterwards.
//      -> an idle cycle between beats does not advance rr_ptr.
//   4. BCAST with out_ready=4'b1011; beat 0x7E, then a second beat
//      -> 0x7E appears on all 4 channels; the second beat stalls until ch2 drains.
//   5. N=3, SEL_W=2, ADDR, in_sel=3, data 0xFF
//      -> in_ready=1, no out_valid change, err=1 for exactly one cycle.
//   6. Assert rst while RR and channels are full
//      -> out_valid=0 immediately, without waiting for an edge.
//      -> after release, the first RR beat goes to ch0.

Source files
------------

// File: rtl/stream_demux.sv
// Registered 1:N valid/ready demultiplexer with addressed, round-robin or broadcast routing.
// Each output channel is a one-entry register; in_ready is combinational from channel state.
module stream_demux #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               err
);

  localparam logic [1:0] MODE_ADDR  = 2'b00;
  localparam logic [1:0] MODE_RR    = 2'b01;
  localparam logic [1:0] MODE_BCAST = 2'b10;

  logic [N-1:0]     free;
  logic [N-1:0]     target;
  logic [N-1:0]     load;
  logic [SEL_W-1:0] rr_ptr;
  logic             sel_ok;
  logic             drop;
  logic             accept;

  assign free   = ~out_valid | out_ready;
  assign sel_ok = int'(in_sel) < N;

  always_comb begin
    in_ready = 1'b0;
    target   = '0;
    drop     = 1'b0;
    case (mode)
      MODE_ADDR: begin
        if (sel_ok) begin
          in_ready       = free[in_sel];
          target[in_sel] = 1'b1;
        end else begin
          // Out-of-range address: swallow the beat so the producer never deadlocks.
          in_ready = 1'b1;
          drop     = 1'b1;
        end
      end
      MODE_RR: begin
        in_ready       = free[rr_ptr];
        target[rr_ptr] = 1'b1;
      end
      MODE_BCAST: begin
        in_ready = &free;
        target   = '1;
      end
      default: ;
    endcase
    if (rst) in_ready = 1'b0;
  end

  assign accept = in_valid & in_ready;
  assign load   = {N{accept}} & target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
      err       <= 1'b0;
    end else begin
      err <= accept & drop;
      if (accept && mode == MODE_RR)
        rr_ptr <= (rr_ptr == SEL_W'(N - 1)) ? '0 : rr_ptr + 1'b1;
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          out_valid[k]                 <= 1'b1;
          out_data[k*WIDTH +: WIDTH]   <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Randomized and directed bench for stream_demux (N=4 main instance, N=3 instance for illegal selects).
module tb_stream_demux;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        err;

  logic        in_valid3;
  logic        in_ready3;
  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic [2:0]  out_valid3;
  logic [23:0] out_data3;
  logic        err3;

  stream_demux #(.N(4), .WIDTH(8), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err(err)
  );

  stream_demux #(.N(3), .WIDTH(8), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .mode(2'b00), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .out_valid(out_valid3), .out_ready(3'b111),
    .out_data(out_data3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: per-channel queue of beats held in that channel, plus a round-robin counter.
  logic [7:0] q [4][$];
  int         rr = 0;
  logic       pv3 = 1'b0;
  logic [1:0] ps3 = 2'b00;
  logic [7:0] pd3 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) q[k].delete();
    rr  = 0;
    pv3 = 1'b0;
  endtask

  // One clock cycle: drive at edge+1, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic [1:0] m, input logic v, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] r);
    logic       exp_rdy;
    logic       acc;
    logic [3:0] tgt;
    logic [2:0] exp_v3;
    logic       v3;
    logic [1:0] s3;
    logic [7:0] d3;
    mode = m; in_valid = v; in_sel = s; in_data = d; out_ready = r;
    v3 = ($urandom_range(0, 1) == 1);
    s3 = 2'($urandom_range(0, 3));
    d3 = 8'($urandom);
    in_valid3 = v3; in_sel3 = s3; in_data3 = d3;
    #4;
    exp_rdy = 1'b0;
    tgt     = 4'b0000;
    case (m)
      2'b00: begin exp_rdy = (q[s].size() == 0) || r[s]; tgt[s] = 1'b1; end
      2'b01: begin exp_rdy = (q[rr].size() == 0) || r[rr]; tgt[rr] = 1'b1; end
      2'b10: begin
        exp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) if (q[k].size() != 0 && !r[k]) exp_rdy = 1'b0;
        tgt = 4'b1111;
      end
      default: ;
    endcase
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      chk("out_valid", 32'(out_valid[k]), 32'(q[k].size() != 0));
      if (q[k].size() != 0) chk("out_data", 32'(out_data[k*8 +: 8]), 32'(q[k][0]));
    end
    chk("err_n4", 32'(err), 32'd0);
    exp_v3 = (pv3 && ps3 < 2'd3) ? (3'b001 << ps3) : 3'b000;
    chk("n3_in_ready", 32'(in_ready3), 32'd1);
    chk("n3_out_valid", 32'(out_valid3), 32'(exp_v3));
    if (exp_v3 != 3'b000) chk("n3_out_data", 32'(out_data3[ps3*8 +: 8]), 32'(pd3));
    chk("n3_err", 32'(err3), 32'(pv3 && ps3 == 2'd3));
    acc = v && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() != 0 && r[k]) void'(q[k].pop_front());
      if (acc && tgt[k]) q[k].push_back(d);
    end
    if (acc && m == 2'b01) rr = (rr + 1) % 4;
    pv3 = v3; ps3 = s3; pd3 = d3;
    #1;
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; mode = 2'b00; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'hF;
    in_valid3 = 1'b0; in_sel3 = 2'd0; in_data3 = 8'h00;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_n3_in_ready", 32'(in_ready3), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Addressed beats to each channel on consecutive cycles.
    for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 2'(i), 8'(8'h11 * (i + 1)), 4'hF);
    chk("addr_last_ch3", 32'(out_data[31:24]), 32'h44);
    step(2'b00, 1'b0, 2'd0, 8'h00, 4'hF);

    // Stalled channel 2, then simultaneous drain and load.
    step(2'b00, 1'b1, 2'd2, 8'hA5, 4'b1011);
    step(2'b00, 1'b1, 2'd2, 8'h5A, 4'b1011);
    chk("hold_ch2", 32'(out_data[23:16]), 32'hA5);
    step(2'b00, 1'b1, 2'd2, 8'h5A, 4'b1111);
    chk("b2b_valid_ch2", 32'(out_valid[2]), 32'd1);
    chk("b2b_data_ch2", 32'(out_data[23:16]), 32'h5A);
    step(2'b00, 1'b0, 2'd0, 8'h00, 4'hF);

    // Round-robin order with an idle cycle that must not advance the pointer.
    for (int i = 0; i < 6; i++) begin
      step(2'b01, 1'b1, 2'd0, 8'(i + 1), 4'hF);
      chk("rr_channel", 32'(out_valid), 32'(4'b0001 << rr_exp[i]));
      if (i == 2) begin
        step(2'b01, 1'b0, 2'd0, 8'h00, 4'hF);
        chk("rr_idle", 32'(out_valid), 32'd0);
      end
    end
    step(2'b01, 1'b1, 2'd0, 8'h07, 4'hF);
    chk("rr_ptr_after6", 32'(out_valid), 32'b0100);
    step(2'b00, 1'b0, 2'd0, 8'h00, 4'hF);

    // Broadcast, then a second beat that must wait for channel 2.
    step(2'b10, 1'b1, 2'd0, 8'h7E, 4'b1011);
    chk("bcast_valid", 32'(out_valid), 32'hF);
    chk("bcast_data", out_data, 32'h7E7E7E7E);
    step(2'b10, 1'b1, 2'd0, 8'h33, 4'b1011);
    chk("bcast_stall", 32'(out_valid), 32'b0100);
    step(2'b10, 1'b1, 2'd0, 8'h33, 4'b1111);
    chk("bcast_second", out_data, 32'h33333333);

    // Fill all channels in RR mode, then reset between edges.
    for (int i = 0; i < 5; i++) step(2'b01, 1'b1, 2'd0, 8'(8'hC0 + i), 4'h0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_n3_valid", 32'(out_valid3), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    step(2'b01, 1'b1, 2'd0, 8'h99, 4'hF);
    chk("post_rst_rr_ch0", 32'(out_valid), 32'b0001);
    chk("post_rst_rr_data", 32'(out_data[7:0]), 32'h99);

    // Randomized traffic across all modes including reserved.
    for (int i = 0; i < 3000; i++) begin
      int         msel;
      logic [1:0] m;
      msel = $urandom_range(0, 9);
      m = (msel < 3) ? 2'b00 : (msel < 6) ? 2'b01 : (msel < 9) ? 2'b10 : 2'b11;
      step(m, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
           4'($urandom | $urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
